// File: rtl/demux_frame_ctrl.sv
// Purpose: steers a serial valid/ready bit stream into 8 channel registers.
//          Bits go to the enabled channels in ascending order, and the assembled frame is held until it is acknowledged.
// Latency: a bit accepted at edge t lands in out_o[sel_o(t)] at edge t.
//          frame_valid_o rises on the edge of the last transfer.
// Backpressure: in_ready_o is high only while filling. A bit offered while not ready raises a one-cycle ovf_o pulse.
// Ports: clk/rst_n (async active-low); in_i/in_valid_i/in_ready_o serial input;
//        en_mask_i channel enables (sampled at frame start); frame_ack_i consumer ack;
//        sel_o demux select; out_o channel registers; frame_valid_o frame held; ovf_o overflow pulse.
module demux_frame_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] en_mask_i,
    input  logic       frame_ack_i,
    output logic [2:0] sel_o,
    output logic [7:0] out_o,
    output logic       frame_valid_o,
    output logic       ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    logic [7:0] out_q,   out_d;
    logic [7:0] mask_q,  mask_d;
    logic       ovf_q,   ovf_d;

    logic       xfer;
    logic [7:0] above_bits;
    logic       last_chan;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign xfer       = in_valid_i && (state_q == FILL);
    // Enabled channels strictly above the current one; empty means sel_q is the last channel.
    assign above_bits = mask_q & (8'hFE << sel_q);
    assign last_chan  = (above_bits == 8'h00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            out_q   <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_mask_i != 8'h00)  state_d = FILL;
            FILL:    if (xfer && last_chan)   state_d = HOLD;
            HOLD:    if (frame_ack_i)         state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        sel_d  = sel_q;
        out_d  = out_q;
        mask_d = mask_q;
        // The overflow flag is evaluated in every state, including FILL where it is always 0.
        ovf_d  = in_valid_i && (state_q != FILL);
        unique case (state_q)
            IDLE: begin
                if (en_mask_i != 8'h00) begin
                    mask_d = en_mask_i;
                    sel_d  = lowest_set(en_mask_i);
                    out_d  = '0;
                end
            end
            FILL: begin
                if (xfer) begin
                    out_d[sel_q] = in_i;
                    // On the last channel, sel holds so it stays frozen through HOLD.
                    if (!last_chan) sel_d = lowest_set(above_bits);
                end
            end
            default: ;
        endcase
    end

    // Outputs (Moore)
    always_comb begin
        in_ready_o    = (state_q == FILL);
        frame_valid_o = (state_q == HOLD);
    end

    assign sel_o = sel_q;
    assign out_o = out_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_demux_frame_ctrl.sv
module tb_demux_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] en_mask;
    logic       frame_ack;
    logic [2:0] sel;
    logic [7:0] out_v;
    logic       frame_valid;
    logic       ovf;

    always #5 clk = ~clk;

    demux_frame_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_i          (in_b),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .en_mask_i     (en_mask),
        .frame_ack_i   (frame_ack),
        .sel_o         (sel),
        .out_o         (out_v),
        .frame_valid_o (frame_valid),
        .ovf_o         (ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference model: mode 0 = waiting, 1 = collecting bits, 2 = frame held.
    int         m_mode;
    int         chans[$];   // enabled channel indices, ascending
    int         pos;        // transfers done in current frame
    logic [7:0] m_out;
    logic [2:0] m_sel;
    logic       m_ovf;
    int         sel_log[$];

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_out = '0; m_sel = '0; m_ovf = 1'b0; pos = 0;
        chans.delete();
    endtask

    // Applies one clock edge's worth of behaviour using the inputs seen at that edge.
    task automatic model_edge();
        m_ovf = in_valid && (m_mode != 1);
        case (m_mode)
            0: if (en_mask != 0) begin
                chans.delete();
                for (int k = 0; k < 8; k++) if (en_mask[k]) chans.push_back(k);
                pos = 0; m_out = '0; m_sel = 3'(chans[0]); m_mode = 1;
            end
            1: if (in_valid) begin
                m_out[chans[pos]] = in_b;
                if (pos == chans.size() - 1) m_mode = 2;
                else begin pos++; m_sel = 3'(chans[pos]); end
            end
            default: if (frame_ack) m_mode = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, " in_ready"},    {7'd0, in_ready},    {7'd0, m_mode == 1});
        chk({tag, " frame_valid"}, {7'd0, frame_valid}, {7'd0, m_mode == 2});
        chk({tag, " sel"},         {5'd0, sel},         {5'd0, m_sel});
        chk({tag, " out"},         out_v,               m_out);
        chk({tag, " ovf"},         {7'd0, ovf},         {7'd0, m_ovf});
    endtask

    task automatic tick(input string tag);
        if (in_ready && in_valid) sel_log.push_back(int'(sel));
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // vmode: 0 = valid always high, 1 = toggling while filling (low otherwise), 2 = random.
    // Returns the number of edges until frame_valid is seen.
    task automatic run_frame(input string tag, input logic [7:0] mask, input logic [7:0] pat,
                             input int vmode, output int cyc);
        int fc;
        fc  = 0;
        cyc = 0;
        sel_log.delete();
        en_mask   = mask;
        frame_ack = 1'b0;
        while (!frame_valid && cyc < 200) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = (m_mode == 1) && (fc % 2 == 0); if (m_mode == 1) fc++; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_b = (m_mode == 1) ? pat[pos] : 1'($urandom_range(0, 1));
            tick(tag);
            cyc++;
        end
        chk({tag, " timeout"}, {7'd0, frame_valid}, 8'd1);
        en_mask  = 8'h00;
        in_valid = 1'b0;
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        tick(tag);
        frame_ack = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] pat;
        logic [7:0] held;

        rst_n = 1'b0; in_b = 1'b0; in_valid = 1'b0; en_mask = 8'h00; frame_ack = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full mask, valid held high.
        run_frame("full", 8'hFF, 8'b0100_1101, 0, cyc);
        chk("full latency", 8'(cyc), 8'd9);
        chk("full out", out_v, 8'h4D);
        chk("full sel_cnt", 8'(sel_log.size()), 8'd8);
        for (int i = 0; i < 8 && i < sel_log.size(); i++)
            chk("full sel_seq", 8'(sel_log[i]), 8'(i));

        // Hold with no ack, valid high: frozen frame, ovf every cycle.
        held = out_v;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick("hold");
        chk("hold out", out_v, held);
        chk("hold sel", {5'd0, sel}, 8'd7);
        chk("hold ovf", {7'd0, ovf}, 8'd1);
        in_valid = 1'b0;
        en_mask  = 8'hFF;
        ack_frame("ack");
        chk("ack idle", {6'd0, frame_valid, in_ready}, 8'd0);
        tick("refill");
        chk("refill out", out_v, 8'h00);
        chk("refill ready", {7'd0, in_ready}, 8'd1);
        en_mask = 8'h00;
        // Finish the restarted frame then release it.
        run_frame("refill", 8'h00, 8'h5A, 0, cyc);
        ack_frame("ack2");

        // Sparse mask.
        run_frame("sparse", 8'b1010_0100, 8'h07, 0, cyc);
        chk("sparse latency", 8'(cyc), 8'd4);
        chk("sparse out", out_v, 8'hA4);
        chk("sparse sel_cnt", 8'(sel_log.size()), 8'd3);
        if (sel_log.size() == 3) begin
            chk("sparse sel0", 8'(sel_log[0]), 8'd2);
            chk("sparse sel1", 8'(sel_log[1]), 8'd5);
            chk("sparse sel2", 8'(sel_log[2]), 8'd7);
        end
        ack_frame("ack3");

        // Toggling valid: no overflow, 8 transfers.
        run_frame("toggle", 8'hFF, 8'h96, 1, cyc);
        chk("toggle out", out_v, 8'h96);
        chk("toggle xfers", 8'(sel_log.size()), 8'd8);
        ack_frame("ack4");

        // Empty mask keeps the block idle; then a single-channel frame.
        for (int i = 0; i < 4; i++) tick("empty");
        chk("empty ready", {7'd0, in_ready}, 8'd0);
        run_frame("single", 8'h01, 8'h01, 0, cyc);
        chk("single latency", 8'(cyc), 8'd2);
        chk("single out", out_v, 8'h01);
        chk("single sel", {5'd0, sel}, 8'd0);
        ack_frame("ack5");

        // Reset in the middle of a frame.
        en_mask = 8'hFF; in_valid = 1'b1; in_b = 1'b1;
        tick("mid");
        en_mask = 8'h00;
        for (int i = 0; i < 4; i++) tick("mid");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid_rst out", out_v, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 8'hF0, 8'h0B, 0, cyc);
        chk("post_rst out", out_v, 8'hB0);
        if (sel_log.size() > 0) chk("post_rst first_sel", 8'(sel_log[0]), 8'd4);
        ack_frame("ack6");

        // Randomized frames with random valid and random ack delay.
        for (int f = 0; f < 30; f++) begin
            pat = 8'($urandom);
            run_frame("rand", 8'($urandom_range(1, 255)), pat, 2, cyc);
            frame_ack = 1'b0;
            for (int i = $urandom_range(0, 3); i > 0; i--) begin
                in_valid = 1'($urandom_range(0, 1));
                tick("rand_hold");
            end
            in_valid = 1'($urandom_range(0, 1));
            ack_frame("rand_ack");
            in_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_frame_ctrl.md
# demux_frame_ctrl

Controller that sequences a 1-to-8 demultiplexer. A serial bit stream arrives under a valid/ready handshake. The block steers each accepted bit to the next enabled output channel in ascending order. It holds the assembled 8-bit frame until the consumer acknowledges it. It sits between a serial source and the demux datapath: it drives the 3-bit channel select and owns the per-channel output registers.

## Interface
- No parameters: channel count fixed at 8, select width fixed at 3.

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- in  in  1  serial data bit
- in_valid  in  1  source has a bit on `in`
- in_ready  out  1  controller accepts a bit this cycle
- en_mask  in  8  channel enables; bit k enables channel k; sampled only at frame start
- frame_ack  in  1  consumer has taken the held frame
- sel  out  3  current target channel (demux select)
- out  out  8  channel registers; out[k] is the last bit steered to channel k in this frame
- frame_valid  out  1  `out` holds a complete frame
- ovf  out  1  one-cycle pulse; a bit was offered while not ready

## Operation
- States: IDLE, FILL, HOLD. All outputs are registered or decoded from state only (Moore).
- Decodes:
  - in_ready = (state == FILL)
  - frame_valid = (state == HOLD)
- Reset (async, rst_n=0): state=IDLE, sel=0, out=0, mask_q=0, ovf=0, in_ready=0, frame_valid=0.
- IDLE:
  - en_mask == 0: remain in IDLE.
  - Otherwise, next edge: mask_q <= en_mask; sel <= index of lowest set bit; out <= 0; state <= FILL.
- FILL:
  - A transfer occurs on an edge where in_valid & in_ready.
  - On a transfer, out[sel] <= in.
  - If sel is the highest set bit of mask_q: state <= HOLD and sel holds its value.
  - Otherwise sel <= next set bit of mask_q above sel. Disabled channels are skipped with no idle cycle.
  - No transfer: everything holds.
- HOLD:
  - out, sel and mask_q are frozen.
  - frame_ack=1: state <= IDLE at the next edge.
  - frame_ack is ignored in IDLE and FILL.
- Disabled channels stay 0 in `out` for the whole frame.
- en_mask changes during FILL or HOLD have no effect until the next IDLE→FILL transition.
- ovf <= in_valid & ~in_ready, evaluated every cycle, in all states.
- An X on `in` during a transfer is stored as-is; no checking.

## Timing
- Select steering:
  - sel is valid in the same cycle as in_ready, so the demux path is combinational from sel.
  - The bit transferred at edge t lands in out[sel(t)] at edge t.
- Frame latency for N enabled channels with in_valid held high:
  - 1 cycle IDLE→FILL.
  - N transfer cycles.
  - frame_valid rises on the edge of the N-th transfer.
- Back-to-back frames with frame_ack tied high: frame period = N + 2 cycles (FILL N, HOLD 1, IDLE 1).
- Single-channel mask: FILL lasts exactly one transfer; sel stays constant.
- rst_n asserted mid-FILL or mid-HOLD:
  - Immediate return to IDLE.
  - out cleared and the partial frame discarded.
  - No frame_valid pulse.
- After rst_n deasserts, the first IDLE→FILL edge occurs no earlier than the first clk edge with rst_n=1.

## Test plan
- Reset, then en_mask=8'hFF with in_valid=1 and bits 1,0,1,1,0,0,1,0:
  - sel steps 0..7.
  - frame_valid rises 9 cycles after the start edge.
  - out=8'b0100_1101 (out[0]=1 first).
- en_mask=8'b1010_0100 with bits 1,1,1:
  - sel steps 2,5,7.
  - out=8'b1010_0100.
  - frame_valid after 3 transfers.
- Full mask with in_valid toggling 1,0,1,0…:
  - sel advances only on transfer cycles.
  - Frame completes after 8 transfers / 16 cycles.
  - ovf stays 0.
- In HOLD with frame_ack=0 for 5 cycles and in_valid=1:
  - out and sel stay frozen.
  - ovf pulses each cycle.
  - frame_ack=1 → IDLE next edge, then FILL with out=0.
- en_mask=0 in IDLE: in_ready stays 0 and state stays IDLE. Then en_mask=8'h01 → FILL with sel=0; one transfer → HOLD.
- rst_n pulsed low after 4 of 8 transfers:
  - out=0, frame_valid=0, in_ready=0 immediately.
  - The next frame starts from the lowest enabled channel.
